// File: rtl/mem_stage.sv
// Memory-access stage: branch resolution, data-memory load/store with a
// configurable multi-edge latency, upstream stall, and the MEM/WB register.
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int REG_W   = 3,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic              in_Branch,
    input  logic [DATA_W-1:0] in_BranchTarget,
    input  logic              in_MemtoReg,
    input  logic              in_RegWrite,
    input  logic [DATA_W-1:0] in_ALUResult,
    input  logic              in_Zero,
    input  logic [DATA_W-1:0] in_Write_Data,
    input  logic [REG_W-1:0]  in_WriteRegister,
    output logic              O_PCSrc,
    output logic [DATA_W-1:0] O_BranchTarget,
    output logic              O_Stall,
    output logic              O_RegWrite,
    output logic              O_MemtoReg,
    output logic [DATA_W-1:0] O_ReadData,
    output logic [DATA_W-1:0] O_ALUResult,
    output logic [REG_W-1:0]  O_WriteRegister
);

    typedef enum logic {IDLE, WAIT} state_e;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         MULTI    = (MEM_LAT > 1);
    localparam logic [3:0] CNT_INIT = MULTI ? 4'(MEM_LAT - 2) : 4'd0;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;

    // Access fields captured at issue so EX/MEM may change during WAIT.
    logic [DATA_W-1:0]  alu_lat_q, wdata_lat_q;
    logic               mw_lat_q, m2r_lat_q, rw_lat_q;
    logic [REG_W-1:0]   wreg_lat_q;
    logic               latch_en;

    logic               wb_rw_q, wb_rw_d;
    logic               wb_m2r_q, wb_m2r_d;
    logic [DATA_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_alu_q, wb_alu_d;
    logic [REG_W-1:0]   wb_wreg_q, wb_wreg_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               memop, complete, stall, mem_we;
    logic               sel_mw, sel_m2r, sel_rw;
    logic [DATA_W-1:0]  sel_alu, sel_wdata, mem_rdata;
    logic [REG_W-1:0]   sel_wreg;
    logic [ADDR_W-1:0]  sel_addr;

    assign O_PCSrc        = in_Branch & in_Zero;
    assign O_BranchTarget = in_BranchTarget;
    assign O_Stall        = stall;

    assign memop = in_MemRead | in_MemWrite;

    always_comb begin
        if (state_q == WAIT) begin
            sel_alu   = alu_lat_q;
            sel_wdata = wdata_lat_q;
            sel_mw    = mw_lat_q;
            sel_m2r   = m2r_lat_q;
            sel_rw    = rw_lat_q;
            sel_wreg  = wreg_lat_q;
        end else begin
            sel_alu   = in_ALUResult;
            sel_wdata = in_Write_Data;
            sel_mw    = in_MemWrite;
            sel_m2r   = in_MemtoReg;
            sel_rw    = in_RegWrite;
            sel_wreg  = in_WriteRegister;
        end
    end

    assign sel_addr  = sel_alu[ADDR_W-1:0];
    assign mem_rdata = mem[sel_addr];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        latch_en = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop && MULTI) begin
                    stall    = 1'b1;
                    latch_en = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = WAIT;
                end else begin
                    complete = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bubbles clear only the control bits; data fields keep their last value.
    always_comb begin
        wb_rw_d   = 1'b0;
        wb_m2r_d  = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_alu_d  = wb_alu_q;
        wb_wreg_d = wb_wreg_q;
        if (complete) begin
            wb_rw_d   = sel_rw;
            wb_m2r_d  = sel_m2r;
            wb_rd_d   = mem_rdata;
            wb_alu_d  = sel_alu;
            wb_wreg_d = sel_wreg;
        end
    end

    assign mem_we = complete & sel_mw & rst_n;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_lat_q   <= '0;
            wdata_lat_q <= '0;
            mw_lat_q    <= 1'b0;
            m2r_lat_q   <= 1'b0;
            rw_lat_q    <= 1'b0;
            wreg_lat_q  <= '0;
        end else if (latch_en) begin
            alu_lat_q   <= in_ALUResult;
            wdata_lat_q <= in_Write_Data;
            mw_lat_q    <= in_MemWrite;
            m2r_lat_q   <= in_MemtoReg;
            rw_lat_q    <= in_RegWrite;
            wreg_lat_q  <= in_WriteRegister;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rw_q   <= 1'b0;
            wb_m2r_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_alu_q  <= '0;
            wb_wreg_q <= '0;
        end else begin
            wb_rw_q   <= wb_rw_d;
            wb_m2r_q  <= wb_m2r_d;
            wb_rd_q   <= wb_rd_d;
            wb_alu_q  <= wb_alu_d;
            wb_wreg_q <= wb_wreg_d;
        end
    end

    // Read above samples the pre-write word, giving read-before-write.
    always_ff @(negedge clk) begin
        if (mem_we) mem[sel_addr] <= sel_wdata;
    end

    assign O_RegWrite      = wb_rw_q;
    assign O_MemtoReg      = wb_m2r_q;
    assign O_ReadData      = wb_rd_q;
    assign O_ALUResult     = wb_alu_q;
    assign O_WriteRegister = wb_wreg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_stage;

    typedef struct packed {
        logic        mr, mw, br;
        logic [15:0] bt;
        logic        m2r, rw;
        logic [15:0] alu;
        logic        z;
        logic [15:0] wd;
        logic [2:0]  wr;
    } in_t;

    typedef struct packed {
        logic        rw, m2r;
        logic [15:0] rd, alu;
        logic [2:0]  wr;
    } exp_t;

    logic        clk = 1'b1;
    logic        rst_n = 1'b0;
    in_t         vin [2];
    logic        pcsrc [2], stall [2], rw [2], m2r [2];
    logic [15:0] bto [2], rd [2], aluo [2];
    logic [2:0]  wro [2];

    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_MemRead(vin[0].mr), .in_MemWrite(vin[0].mw), .in_Branch(vin[0].br),
        .in_BranchTarget(vin[0].bt), .in_MemtoReg(vin[0].m2r), .in_RegWrite(vin[0].rw),
        .in_ALUResult(vin[0].alu), .in_Zero(vin[0].z), .in_Write_Data(vin[0].wd),
        .in_WriteRegister(vin[0].wr),
        .O_PCSrc(pcsrc[0]), .O_BranchTarget(bto[0]), .O_Stall(stall[0]),
        .O_RegWrite(rw[0]), .O_MemtoReg(m2r[0]), .O_ReadData(rd[0]),
        .O_ALUResult(aluo[0]), .O_WriteRegister(wro[0])
    );

    mem_stage #(.MEM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_MemRead(vin[1].mr), .in_MemWrite(vin[1].mw), .in_Branch(vin[1].br),
        .in_BranchTarget(vin[1].bt), .in_MemtoReg(vin[1].m2r), .in_RegWrite(vin[1].rw),
        .in_ALUResult(vin[1].alu), .in_Zero(vin[1].z), .in_Write_Data(vin[1].wd),
        .in_WriteRegister(vin[1].wr),
        .O_PCSrc(pcsrc[1]), .O_BranchTarget(bto[1]), .O_Stall(stall[1]),
        .O_RegWrite(rw[1]), .O_MemtoReg(m2r[1]), .O_ReadData(rd[1]),
        .O_ALUResult(aluo[1]), .O_WriteRegister(wro[1])
    );

    function automatic in_t mk(input logic mr, input logic mw, input logic rwi,
                               input logic m2ri, input logic [15:0] alu,
                               input logic [15:0] wd, input logic [2:0] wr);
        in_t v = '0;
        v.mr = mr; v.mw = mw; v.rw = rwi; v.m2r = m2ri;
        v.alu = alu; v.wd = wd; v.wr = wr;
        return v;
    endfunction

    // Issue one op, hold it through any stall, then score the writeback.
    task automatic run_op(input int d, input in_t v, input int exp_stalls,
                          input bit corrupt, input logic [15:0] exp_rd, input string nm);
        int   stalls = 0;
        bit   done = 0;
        exp_t e;
        if (v.rw) begin
            e.rw = 1'b1; e.m2r = v.m2r; e.rd = exp_rd; e.alu = v.alu; e.wr = v.wr;
            sb.push_back(e);
        end
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #1;
            vin[d] = v;
            if (corrupt && c > 0) vin[d].alu = v.alu ^ 16'h00F0;
            #1;
            if (stall[d] === 1'b1) begin
                stalls++;
                @(negedge clk); #1;
                checks++;
                if (rw[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s bubble_regwrite got=%0b exp=0", nm, rw[d]);
                end
            end else begin
                @(negedge clk); #1;
                done = 1;
            end
        end
        vin[d] = '0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout got=stalled exp=complete", nm);
        end
        checks++;
        if (stalls != exp_stalls) begin
            failures++;
            $display("FAIL %s stall_edges got=%0d exp=%0d", nm, stalls, exp_stalls);
        end
        if (rw[d] === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected_writeback got=1 exp=0", nm);
            end else begin
                e = sb.pop_front();
                if (m2r[d] !== e.m2r || aluo[d] !== e.alu || wro[d] !== e.wr ||
                    (e.m2r && rd[d] !== e.rd)) begin
                    failures++;
                    $display("FAIL %s writeback got=m2r%0b/alu%h/wr%0d/rd%h exp=m2r%0b/alu%h/wr%0d/rd%h",
                             nm, m2r[d], aluo[d], wro[d], rd[d], e.m2r, e.alu, e.wr, e.rd);
                end
            end
        end else if (v.rw) begin
            checks++;
            failures++;
            void'(sb.pop_front());
            $display("FAIL %s writeback_missing got=%0b exp=1", nm, rw[d]);
        end
    endtask

    task automatic check_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rw[d] !== 1'b0 || m2r[d] !== 1'b0 || rd[d] !== 16'h0 ||
                aluo[d] !== 16'h0 || wro[d] !== 3'd0 || stall[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s dut%0d got=rw%0b/m2r%0b/rd%h/alu%h/wr%0d/st%0b exp=all0",
                         nm, d, rw[d], m2r[d], rd[d], aluo[d], wro[d], stall[d]);
            end
        end
    endtask

    task automatic test_reset;
        #2;
        check_zero("reset_init");
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        run_op(0, mk(0, 0, 1, 0, 16'h00FF, 16'h0, 3'd7), 0, 0, 16'h0, "alu_op");
        run_op(0, mk(0, 0, 1, 0, 16'h1234, 16'h0, 3'd2), 0, 0, 16'h0, "alu_b2b");
    endtask

    task automatic test_reset_async;
        @(posedge clk); #1;
        checks++;
        if (aluo[0] !== 16'h1234) begin
            failures++;
            $display("FAIL rst_pre alu got=%h exp=1234", aluo[0]);
        end
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        rst_n = 1'b1;
    endtask

    task automatic test_alias;
        run_op(0, mk(0, 1, 0, 0, 16'h0005, 16'hBEEF, 3'd0), 0, 0, 16'h0, "store_l1");
        run_op(0, mk(1, 0, 1, 1, 16'h0105, 16'h0, 3'd3), 0, 0, 16'hBEEF, "load_alias");
    endtask

    task automatic test_rbw;
        run_op(0, mk(1, 1, 1, 1, 16'h0005, 16'h1111, 3'd2), 0, 0, 16'hBEEF, "rbw_old");
        run_op(0, mk(1, 0, 1, 1, 16'h0205, 16'h0, 3'd4), 0, 0, 16'h1111, "rbw_new");
    endtask

    task automatic test_branch;
        @(posedge clk); #1;
        vin[0].br = 1'b1; vin[0].z = 1'b1; vin[0].bt = 16'h0040;
        #1;
        checks++;
        if (pcsrc[0] !== 1'b1 || bto[0] !== 16'h0040) begin
            failures++;
            $display("FAIL branch_taken got=%0b/%h exp=1/0040", pcsrc[0], bto[0]);
        end
        vin[0].z = 1'b0;
        #1;
        checks++;
        if (pcsrc[0] !== 1'b0) begin
            failures++;
            $display("FAIL branch_not_taken got=%0b exp=0", pcsrc[0]);
        end
        vin[0] = '0;
    endtask

    task automatic test_lat3;
        run_op(1, mk(0, 1, 0, 0, 16'h0010, 16'h1234, 3'd0), 2, 0, 16'h0, "store_l3");
        run_op(1, mk(1, 0, 1, 1, 16'h0010, 16'h0, 3'd6), 2, 1, 16'h1234, "load_l3");
        run_op(1, mk(0, 0, 1, 0, 16'h00AB, 16'h0, 3'd1), 0, 0, 16'h0, "alu_l3");
    endtask

    task automatic test_reset_abort;
        run_op(1, mk(0, 1, 0, 0, 16'h0020, 16'h5555, 3'd0), 2, 0, 16'h0, "store_old");
        @(posedge clk); #1;
        vin[1] = mk(0, 1, 0, 0, 16'h0020, 16'hAAAA, 3'd0);
        @(negedge clk); #1;
        vin[1] = '0;
        @(posedge clk); #1;
        checks++;
        if (stall[1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_wait stall got=%0b exp=1", stall[1]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall[1] !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset stall got=%0b exp=0", stall[1]);
        end
        rst_n = 1'b1;
        run_op(1, mk(1, 0, 1, 1, 16'h0020, 16'h0, 3'd5), 2, 0, 16'h5555, "load_after_abort");
    endtask

    initial begin
        vin[0] = '0;
        vin[1] = '0;
        test_reset;
        test_alu;
        test_reset_async;
        test_alias;
        test_rbw;
        test_branch;
        test_lat3;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage that sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It resolves branches, performs data-memory load/store with a configurable access latency, and stalls upstream while an access is in flight. Its results go into an internal MEM/WB pipeline register that feeds the write-back stage.

Parameters:
DATA_W, 16, data/ALU/branch-target word width
ADDR_W, 8, word-address width of data memory; depth = 2**ADDR_W words
REG_W, 3, register-file index width
MEM_LAT, 1, falling edges a memory access occupies; legal range 1..15

Ports:
clk  input  1  stage clock; all registers update on falling edge
rst_n  input  1  reset, asynchronous, active-low
in_MemRead  input  1  load request
in_MemWrite  input  1  store request
in_Branch  input  1  instruction is a conditional branch
in_BranchTarget  input  DATA_W  PC+2+immediate
in_MemtoReg  input  1  WB selects memory data
in_RegWrite  input  1  WB writes register file
in_ALUResult  input  DATA_W  ALU result / memory address
in_Zero  input  1  ALU zero flag
in_Write_Data  input  DATA_W  store data
in_WriteRegister  input  REG_W  destination register
O_PCSrc  output  1  branch taken (combinational)
O_BranchTarget  output  DATA_W  branch target (combinational pass-through)
O_Stall  output  1  upstream must hold EX/MEM contents (combinational)
O_RegWrite  output  1  MEM/WB register write enable
O_MemtoReg  output  1  MEM/WB result select
O_ReadData  output  DATA_W  MEM/WB loaded data
O_ALUResult  output  DATA_W  MEM/WB ALU result
O_WriteRegister  output  REG_W  MEM/WB destination register

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low. While rst_n=0: every registered output is 0, FSM=IDLE, latency counter=0. Data-memory contents are not reset.
- O_PCSrc = in_Branch & in_Zero. O_BranchTarget = in_BranchTarget. Neither is registered.
- Address = in_ALUResult[ADDR_W-1:0]. Upper bits are ignored, so addresses alias modulo depth.
- FSM states:
  - IDLE: no access in flight.
  - WAIT: access in flight, counter counts down.
- Memory op present = in_MemRead | in_MemWrite.
- Non-memory op in IDLE: the MEM/WB register loads on the next falling edge, giving 1-edge latency. O_Stall=0.
- Memory op with MEM_LAT=1: completes on the same edge. Never enters WAIT; O_Stall=0.
- Memory op with MEM_LAT>1, in IDLE:
  - O_Stall=1.
  - On the falling edge, latch address, store data, control and WriteRegister; counter := MEM_LAT-2; go to WAIT.
  - The MEM/WB register loads a bubble: O_RegWrite=0, O_MemtoReg=0, other fields hold.
- WAIT with counter≠0: O_Stall=1, counter decrements, bubble loaded. EX/MEM inputs are ignored; latched values are used.
- WAIT with counter=0: O_Stall=0. This edge is the completion edge:
  - perform the store if MemWrite;
  - O_ReadData := mem[addr];
  - load MEM/WB from the latched fields;
  - go to IDLE.
- O_Stall is high for exactly MEM_LAT-1 falling edges per memory op.
- MemRead and MemWrite both set: the store is performed and O_ReadData returns the pre-write contents (read-before-write).
- On a store completion, O_ReadData is undefined-but-stable (it holds the mem read value). The WB stage ignores it because MemtoReg=0.
- Reset mid-access: abort immediately and return to IDLE. A store not yet at its completion edge is never written.
- Branch resolution is unaffected by stalls; O_PCSrc follows its inputs at all times.

Test Plan:
1. Reset: assert rst_n=0 between edges with outputs non-zero -> all registered outputs 0 immediately, O_Stall=0.
2. MEM_LAT=1, store 0xBEEF at ALUResult 0x0005, then load from 0x0105 with RegWrite=1, MemtoReg=1, WriteRegister=3 -> after the load edge O_ReadData=0xBEEF (alias), O_WriteRegister=3, O_RegWrite=1; O_Stall never 1.
3. MEM_LAT=3, load from 0x0010 containing 0x1234 -> O_Stall=1 for 2 edges with O_RegWrite=0; third edge O_ReadData=0x1234, O_RegWrite=1. Changing in_ALUResult during WAIT has no effect.
4. Branch: in_Branch=1, in_Zero=1, target 0x0040 -> O_PCSrc=1, O_BranchTarget=0x0040 same cycle; in_Zero=0 -> O_PCSrc=0.
5. MEM_LAT=3, store 0xAAAA to 0x0020 (old 0x5555), pull rst_n low during WAIT -> a later load of 0x0020 returns 0x5555.
6. ALU op: ALUResult 0x00FF, RegWrite=1, MemtoReg=0, WriteRegister=7 -> one edge later O_ALUResult=0x00FF, O_WriteRegister=7, no stall.
